eight_bit_serial_tx: RTL and testbench

EIGHT_BIT_SERIAL_TX -- requirements
Module: eight_bit_serial_tx

---
 rtl/eight_bit_serial_tx.sv | 142 ++++++++++++++
 tb/tb_eight_bit_serial_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/eight_bit_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_serial_tx
// Description : Parallel-to-serial byte transmitter. Frame = start(0),
//               8 data bits LSB first, even parity, stop(1). Each bit lasts
//               CLKS_PER_BIT clocks. TxD/Busy/Done are registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] I,
    input  logic       Load,
    output logic       TxD,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last value of the per-bit cycle counter; 0 when one clock per bit.
    localparam logic [7:0] C_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;

    assign bit_end = (cnt_q == C_LAST);

    // State and output registers; reset returns the line to idle-high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; TxD is computed one edge ahead so it is registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Bit timer runs in every non-idle state and wraps at each bit boundary.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (Load) begin
                    state_d = START;
                    shift_d = I;
                    par_d   = ^I;
                    cnt_d   = 8'd0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                        txd_d   = par_q;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign TxD  = txd_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_eight_bit_serial_tx
// Description : Self-checking bench for eight_bit_serial_tx. Two instances
//               (4 clocks/bit and 1 clock/bit) are compared every cycle
//               against a frame-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eight_bit_serial_tx;

    logic       clk = 1'b0;
    logic       rst_v  [2];
    logic       load_v [2];
    logic [7:0] din    [2];
    logic       txd_o  [2];
    logic       busy_o [2];
    logic       done_o [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a frame is "active" for 11*cpb cycles after acceptance.
    bit         m_active [2];
    int         m_t      [2];
    logic [7:0] m_byte   [2];
    bit         m_done   [2];

    always #5 clk = ~clk;

    eight_bit_serial_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .Clk (clk), .Rst (rst_v[0]), .I (din[0]), .Load (load_v[0]),
        .TxD (txd_o[0]), .Busy (busy_o[0]), .Done (done_o[0])
    );

    eight_bit_serial_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .Clk (clk), .Rst (rst_v[1]), .I (din[1]), .Load (load_v[1]),
        .TxD (txd_o[1]), .Busy (busy_o[1]), .Done (done_o[1])
    );

    function automatic int cpb(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Bit k of the serial frame for byte b, in transmission order.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0)  return 1'b0;
        if (k <= 8)  return b[k-1];
        if (k == 9)  return ^b;
        return 1'b1;
    endfunction

    task automatic model_step(input int k);
        if (rst_v[k]) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
        end else if (m_active[k]) begin
            m_t[k]++;
            m_done[k] = 1'b0;
            if (m_t[k] == 11 * cpb(k)) begin
                m_active[k] = 1'b0;
                m_done[k]   = 1'b1;
            end
        end else begin
            m_done[k] = 1'b0;
            if (load_v[k]) begin
                m_active[k] = 1'b1;
                m_t[k]      = 0;
                m_byte[k]   = din[k];
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: advance the model at the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "txd_cpb4"  : "txd_cpb1",  txd_o[k],
                  m_active[k] ? fbit(m_byte[k], m_t[k] / cpb(k)) : 1'b1);
            check(k == 0 ? "busy_cpb4" : "busy_cpb1", busy_o[k], m_active[k]);
            check(k == 0 ? "done_cpb4" : "done_cpb1", done_o[k], m_done[k]);
        end
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; load_v[k] = 1'b0; din[k] = 8'h00;
            m_active[k] = 1'b0; m_t[k] = 0; m_byte[k] = 8'h00; m_done[k] = 1'b0;
        end

        // Reset for two cycles, then idle.
        ticks(2);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        ticks(3);

        // Single frame 0x01.
        din[0] = 8'h01; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        ticks(50);

        // 0xFF then 0x81 loaded on the Done cycle (back-to-back).
        din[0] = 8'hFF; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        for (int n = 0; n < 60 && !m_done[0]; n++) tick();
        check("done_wait_ff", done_o[0], 1'b1);
        din[0] = 8'h81; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        ticks(50);

        // 0x02 with a second Load and a toggling I mid-frame.
        din[0] = 8'h02; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        for (int n = 1; n < 48; n++) begin
            din[0]    = 8'($urandom);
            load_v[0] = (n == 10);
            if (n == 10) din[0] = 8'h55;
            tick();
        end
        load_v[0] = 1'b0;
        ticks(4);

        // 0x03 aborted by reset in DATA, then 0x04.
        din[0] = 8'h03; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        ticks(19);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        din[0] = 8'h04; load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        ticks(50);

        // One clock per bit: 0xA5.
        din[1] = 8'hA5; load_v[1] = 1'b1;
        tick();
        load_v[1] = 1'b0;
        ticks(15);

        // Randomized traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                rst_v[k]  = ($urandom_range(0, 199) == 0);
                load_v[k] = ($urandom_range(0, 7) == 0);
                din[k]    = 8'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b0; load_v[k] = 1'b0;
        end
        ticks(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
